set_bit_scanner: RTL and testbench



---
 rtl/set_bit_scanner.sv | 126 ++++++++++++
 tb/tb_set_bit_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_scanner.sv
// set_bit_scanner
//
// Splits a merged flag/request mask back into individual requests. One WIDTH-bit mask is
// accepted on the load handshake. The index of every set bit is then presented on the idx
// handshake, one per transfer, lowest bit first. Each accepted index is cleared from the
// internal copy of the mask. A zero mask produces no indices, only the done pulse.
//
// Parameters:
//   WIDTH  mask width in bits (power of two, >= 2)
//   IDX_W  index width, log2(WIDTH)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   load_valid  load_data is valid
//   load_ready  block can accept a new mask (idle and not in reset)
//   load_data   mask to scan
//   idx_valid   idx holds a valid set-bit index
//   idx_ready   consumer accepts idx this cycle
//   idx         index of the lowest remaining set bit
//   idx_last    idx is the final set bit of the current mask
//   done        one-cycle pulse once the current mask is fully consumed
//   count       number of indices accepted for the current mask

module set_bit_scanner #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             done,
    output logic [IDX_W:0]   count
);

    localparam int unsigned CntW = IDX_W + 1;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  mask_q;
    logic [CntW-1:0]   count_q;
    logic              done_q;

    logic              load_fire;
    logic              idx_fire;
    logic [WIDTH-1:0]  mask_rest;
    logic [IDX_W-1:0]  idx_enc;
    logic              enc_found;

    // Gating with rst keeps load_ready low for the whole reset window, independent of
    // the state register.
    assign load_ready = (state_q == StIdle) && !rst;
    assign idx_valid  = (state_q == StScan);
    assign load_fire  = load_valid && load_ready;
    assign idx_fire   = idx_valid && idx_ready;

    // mask & (mask - 1) removes exactly the lowest set bit, which is the bit idx points at.
    assign mask_rest  = mask_q & (mask_q - WIDTH'(1));

    // Lowest-set-bit priority encoder over the registered mask.
    always_comb begin
        idx_enc   = '0;
        enc_found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!enc_found && mask_q[i]) begin
                idx_enc   = IDX_W'(i);
                enc_found = 1'b1;
            end
        end
    end

    assign idx      = idx_enc;
    // Single bit set: nonzero, and nothing left once the lowest bit is removed.
    assign idx_last = (mask_q != '0) && (mask_rest == '0);
    assign done     = done_q;
    assign count    = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_fire) begin
                        count_q <= '0;
                        if (load_data != '0) begin
                            mask_q  <= load_data;
                            state_q <= StScan;
                        end else begin
                            // Nothing to emit: the empty mask completes immediately.
                            done_q <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (idx_fire) begin
                        mask_q  <= mask_rest;
                        count_q <= count_q + CntW'(1);
                        if (idx_last) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Testbench for set_bit_scanner: directed cases followed by random masks with random
// consumer back-pressure. Expected indices come from a per-mask queue of set-bit positions.

module tb_set_bit_scanner;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 5;

    logic             clk;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             done;
    logic [IDX_W:0]   count;

    int n_pass;
    int n_total;

    set_bit_scanner #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .idx_last   (idx_last),
        .done       (done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Loads mask m, drains it and checks every presented index against the list of set-bit
    // positions. Ends on the cycle after the final handshake (the done cycle).
    task automatic scan_mask(input logic [WIDTH-1:0] m, input int stall_first,
                             input bit rand_ready);
        int   q[$];
        int   n;
        int   taken;
        logic rdy;
        for (int b = 0; b < WIDTH; b++) begin
            if (m[b]) q.push_back(b);
        end
        n     = q.size();
        taken = 0;
        chk("load_ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        load_data  = m;
        @(negedge clk);
        load_valid = 1'b0;
        if (n == 0) begin
            chk("zero_idx_valid", idx_valid, 0);
            chk("zero_done", done, 1);
            chk("zero_count", count, 0);
            chk("zero_load_ready", load_ready, 1);
            return;
        end
        for (int c = 0; c < 8 * WIDTH && q.size() > 0; c++) begin
            chk("idx_valid", idx_valid, 1);
            chk("idx", idx, q[0]);
            chk("idx_last", idx_last, q.size() == 1);
            chk("count_mid", count, taken);
            chk("done_mid", done, 0);
            chk("load_ready_mid", load_ready, 0);
            rdy        = (c < stall_first) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            idx_ready  = rdy;
            // Loads offered during a scan must be ignored.
            load_valid = 1'($urandom_range(0, 1));
            load_data  = $urandom;
            @(negedge clk);
            if (rdy) begin
                void'(q.pop_front());
                taken++;
            end
        end
        load_valid = 1'b0;
        idx_ready  = 1'b0;
        chk("drained_in_budget", q.size(), 0);
        chk("end_idx_valid", idx_valid, 0);
        chk("end_done", done, 1);
        chk("end_count", count, n);
        chk("end_load_ready", load_ready, 1);
    endtask

    task automatic idle_check(input int exp_count);
        @(negedge clk);
        chk("idle_done_dropped", done, 0);
        chk("idle_idx_valid", idx_valid, 0);
        chk("idle_load_ready", load_ready, 1);
        chk("idle_count_held", count, exp_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] m;
        int               sel;
        int               pc;
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        idx_ready  = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_load_ready", load_ready, 0);
            chk("rst_idx_valid", idx_valid, 0);
        end
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_load_ready", load_ready, 1);
        chk("post_rst_idx_valid", idx_valid, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_done", done, 0);

        scan_mask(32'h0000_0092, 0, 1'b0);
        idle_check(3);
        scan_mask(32'h0000_0000, 0, 1'b0);
        idle_check(0);
        scan_mask(32'h8000_0001, 4, 1'b0);
        idle_check(2);
        // Full mask, then a load in the done cycle.
        scan_mask(32'hFFFF_FFFF, 0, 1'b0);
        scan_mask(32'h0000_0004, 0, 1'b0);
        idle_check(1);
        scan_mask(32'h8000_0000, 0, 1'b0);
        idle_check(1);

        // Asynchronous reset in the middle of a scan.
        load_valid = 1'b1;
        load_data  = 32'h0000_00F0;
        @(negedge clk);
        load_valid = 1'b0;
        chk("abort_first_idx", idx, 4);
        idx_ready = 1'b1;
        @(negedge clk);
        idx_ready = 1'b0;
        chk("abort_second_idx", idx, 5);
        chk("abort_count_one", count, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_idx_valid", idx_valid, 0);
        chk("abort_count", count, 0);
        chk("abort_done", done, 0);
        chk("abort_idx", idx, 0);
        chk("abort_idx_last", idx_last, 0);
        chk("abort_load_ready", load_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        idx_ready = 1'b1;
        @(negedge clk);
        chk("abort_rel_load_ready", load_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_stale_idx", idx_valid, 0);
            chk("abort_no_done", done, 0);
        end
        idx_ready = 1'b0;

        // Random masks with random back-pressure.
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)      m = '0;
            else if (sel == 1) m = 32'd1 << $urandom_range(0, WIDTH - 1);
            else if (sel < 4)  m = $urandom & $urandom & $urandom;
            else               m = $urandom;
            scan_mask(m, $urandom_range(0, 3), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                pc = 0;
                for (int b = 0; b < WIDTH; b++) pc += int'(m[b]);
                idle_check(pc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
